// File: rtl/common_incr_counter.sv
// common_incr_counter
//
// Parametrised up/down modulo counter over 0..MAX with registered carry and
// borrow pulses and a sticky overflow flag. In wrap mode the count rolls over
// at the bounds. In saturate mode it holds at the bounds. Either way the
// carry/borrow pulse is raised. It is used for FIFO pointers, retry counters
// and small timers.
//
// Parameters
//   WIDTH    : counter width in bits (1..64)
//   MAX      : inclusive terminal count (1..2**WIDTH-1), held at WIDTH+1 bits
//   SATURATE : 0 = wrap at the bounds, 1 = hold at the bounds
//
// Ports
//   clk          : clock, rising edge
//   resetn       : asynchronous active-low reset
//   i_clear      : synchronous clear to 0 (highest priority)
//   i_load       : synchronous load of i_load_value (clamped to MAX)
//   i_load_value : load data
//   i_inc        : increment request
//   i_dec        : decrement request (inc together with dec is a hold)
//   i_ovf_clr    : clears the sticky overflow flag
//   o_q          : current count
//   o_c          : one-cycle carry pulse (increment at MAX)
//   o_b          : one-cycle borrow pulse (decrement at 0)
//   o_ovf        : sticky carry/borrow/clamp flag
//   o_zero       : o_q == 0
//   o_max        : o_q == MAX
module common_incr_counter #(
  parameter int           WIDTH    = 2,
  parameter logic [WIDTH:0] MAX    = {1'b0, {WIDTH{1'b1}}},
  parameter bit           SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_ovf_clr,
  output logic [WIDTH-1:0] o_q,
  output logic             o_c,
  output logic             o_b,
  output logic             o_ovf,
  output logic             o_zero,
  output logic             o_max
);

  // Largest value a WIDTH-bit count can hold, kept one bit wider so that
  // MAX = 2**WIDTH-1 compares without overflow.
  localparam logic [WIDTH:0]   LIMIT = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] MAX_Q = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

  // Elaboration-time parameter checks.
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("common_incr_counter: WIDTH=%0d outside 1..64", WIDTH);
  end
  if (MAX == '0 || MAX > LIMIT) begin : g_bad_max
    $error("common_incr_counter: MAX=%0d outside 1..2**WIDTH-1", MAX);
  end

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic             c_q;
  logic             b_q;
  logic             ovf_q;
  logic             c_next;
  logic             b_next;
  logic             clamp;
  logic             ovf_next;

  // Next-state decode. Clear beats load, load beats a count step, and inc
  // together with dec is treated as a hold. The compares are done at
  // WIDTH+1 bits. The +1 and -1 steps are only taken strictly inside
  // 0..MAX, so the WIDTH-bit step cannot wrap.
  always_comb begin
    q_next = q;
    c_next = 1'b0;
    b_next = 1'b0;
    clamp  = 1'b0;
    if (i_clear) begin
      q_next = '0;
    end else if (i_load) begin
      if ({1'b0, i_load_value} > MAX) begin
        q_next = MAX_Q;
        clamp  = 1'b1;
      end else begin
        q_next = i_load_value;
      end
    end else if (i_inc && !i_dec) begin
      if ({1'b0, q} == MAX) begin
        c_next = 1'b1;
        q_next = SATURATE ? q : '0;
      end else begin
        q_next = q + ONE_Q;
      end
    end else if (i_dec && !i_inc) begin
      if (q == '0) begin
        b_next = 1'b1;
        q_next = SATURATE ? q : MAX_Q;
      end else begin
        q_next = q - ONE_Q;
      end
    end
    // A new event in the same cycle as a clear request keeps the flag set.
    ovf_next = c_next | b_next | clamp | (ovf_q & ~i_ovf_clr);
  end

  // State register. Reset drops any pulse that is due in the current cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q     <= '0;
      c_q   <= 1'b0;
      b_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q     <= q_next;
      c_q   <= c_next;
      b_q   <= b_next;
      ovf_q <= ovf_next;
    end
  end

  assign o_q    = q;
  assign o_c    = c_q;
  assign o_b    = b_q;
  assign o_ovf  = ovf_q;
  // These flags are decoded from the count register only.
  assign o_zero = (q == '0);
  assign o_max  = ({1'b0, q} == MAX);

endmodule

// File: tb/tb_common_incr_counter.sv
// tb_common_incr_counter
//
// Drives three counters with the same control inputs:
//   u0: WIDTH=2, MAX=3, wrap
//   u1: WIDTH=4, MAX=9, wrap
//   u2: WIDTH=4, MAX=9, saturate
// Each counter is compared every cycle against an integer model of the
// counter rules. Directed steps also check fixed expected values.
module tb_common_incr_counter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = '0;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic       ovf_clr = 1'b0;

  logic [1:0] q0;
  logic [3:0] q1;
  logic [3:0] q2;
  logic       c0, b0, ovf0, zero0, max0;
  logic       c1, b1, ovf1, zero1, max1;
  logic       c2, b2, ovf2, zero2, max2;

  int total = 0;
  int bad = 0;

  // Model state, one entry per instance.
  int mq[3];
  bit mc[3];
  bit mb[3];
  bit movf[3];
  int mmax[3];
  int mwidth[3];
  bit msat[3];

  always #5 clk = ~clk;

  common_incr_counter #(.WIDTH(2), .MAX(3'd3), .SATURATE(1'b0)) u0 (
    .clk(clk), .resetn(resetn), .i_clear(clear), .i_load(load),
    .i_load_value(load_value[1:0]), .i_inc(inc), .i_dec(dec),
    .i_ovf_clr(ovf_clr), .o_q(q0), .o_c(c0), .o_b(b0), .o_ovf(ovf0),
    .o_zero(zero0), .o_max(max0));

  common_incr_counter #(.WIDTH(4), .MAX(5'd9), .SATURATE(1'b0)) u1 (
    .clk(clk), .resetn(resetn), .i_clear(clear), .i_load(load),
    .i_load_value(load_value), .i_inc(inc), .i_dec(dec),
    .i_ovf_clr(ovf_clr), .o_q(q1), .o_c(c1), .o_b(b1), .o_ovf(ovf1),
    .o_zero(zero1), .o_max(max1));

  common_incr_counter #(.WIDTH(4), .MAX(5'd9), .SATURATE(1'b1)) u2 (
    .clk(clk), .resetn(resetn), .i_clear(clear), .i_load(load),
    .i_load_value(load_value), .i_inc(inc), .i_dec(dec),
    .i_ovf_clr(ovf_clr), .o_q(q2), .o_c(c2), .o_b(b2), .o_ovf(ovf2),
    .o_zero(zero2), .o_max(max2));

  // Return every model instance to its reset state.
  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      mq[i] = 0;
      mc[i] = 1'b0;
      mb[i] = 1'b0;
      movf[i] = 1'b0;
    end
  endtask

  // Advance every model instance by one clock, using the current inputs.
  task automatic modelStep();
    for (int i = 0; i < 3; i++) begin
      int v;
      bit clampev;
      clampev = 1'b0;
      mc[i] = 1'b0;
      mb[i] = 1'b0;
      v = int'(load_value) % (1 << mwidth[i]);
      if (clear) begin
        mq[i] = 0;
      end else if (load) begin
        if (v > mmax[i]) begin
          mq[i] = mmax[i];
          clampev = 1'b1;
        end else begin
          mq[i] = v;
        end
      end else if (inc && !dec) begin
        if (mq[i] == mmax[i]) begin
          mc[i] = 1'b1;
          if (!msat[i]) mq[i] = 0;
        end else begin
          mq[i] = mq[i] + 1;
        end
      end else if (dec && !inc) begin
        if (mq[i] == 0) begin
          mb[i] = 1'b1;
          if (!msat[i]) mq[i] = mmax[i];
        end else begin
          mq[i] = mq[i] - 1;
        end
      end
      if (mc[i] || mb[i] || clampev) movf[i] = 1'b1;
      else if (ovf_clr) movf[i] = 1'b0;
    end
  endtask

  task automatic expectEq(input string tag, input int actual, input int expected);
    total++;
    assert (actual === expected) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, actual, expected);
    end
  endtask

  task automatic checkInst(input int idx, input int aq, input bit ac, input bit ab,
                           input bit aovf, input bit az, input bit am);
    expectEq($sformatf("u%0d.q", idx), aq, mq[idx]);
    expectEq($sformatf("u%0d.c", idx), int'(ac), int'(mc[idx]));
    expectEq($sformatf("u%0d.b", idx), int'(ab), int'(mb[idx]));
    expectEq($sformatf("u%0d.ovf", idx), int'(aovf), int'(movf[idx]));
    expectEq($sformatf("u%0d.zero", idx), int'(az), int'(mq[idx] == 0));
    expectEq($sformatf("u%0d.max", idx), int'(am), int'(mq[idx] == mmax[idx]));
  endtask

  task automatic checkOutput();
    checkInst(0, int'(q0), c0, b0, ovf0, zero0, max0);
    checkInst(1, int'(q1), c1, b1, ovf1, zero1, max1);
    checkInst(2, int'(q2), c2, b2, ovf2, zero2, max2);
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare.
  task automatic applyStimulus(input bit s_clear, input bit s_load, input int s_value,
                               input bit s_inc, input bit s_dec, input bit s_ovf_clr);
    clear = s_clear;
    load = s_load;
    load_value = 4'(s_value);
    inc = s_inc;
    dec = s_dec;
    ovf_clr = s_ovf_clr;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  initial begin
    mmax = '{3, 9, 9};
    mwidth = '{2, 4, 4};
    msat = '{1'b0, 1'b0, 1'b1};
    modelReset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    expectEq("reset.zero0", int'(zero0), 1);
    @(negedge clk);
    resetn = 1'b1;

    // Wrap at MAX=3: 1,2,3,0,1 with one carry.
    applyStimulus(0, 0, 0, 1, 0, 0); expectEq("wrap.q1", int'(q0), 1);
    applyStimulus(0, 0, 0, 1, 0, 0); expectEq("wrap.q2", int'(q0), 2);
    applyStimulus(0, 0, 0, 1, 0, 0); expectEq("wrap.q3", int'(q0), 3);
    applyStimulus(0, 0, 0, 1, 0, 0); expectEq("wrap.q0", int'(q0), 0);
    expectEq("wrap.c", int'(c0), 1);
    expectEq("wrap.zero", int'(zero0), 1);
    applyStimulus(0, 0, 0, 1, 0, 0); expectEq("wrap.q4", int'(q0), 1);
    expectEq("wrap.c_drop", int'(c0), 0);
    expectEq("wrap.ovf", int'(ovf0), 1);

    // MAX=9: load 9 then dec, load 0 then dec.
    applyStimulus(0, 1, 9, 0, 0, 1); expectEq("mod9.max", int'(max1), 1);
    applyStimulus(0, 0, 0, 0, 1, 0); expectEq("mod9.q8", int'(q1), 8);
    expectEq("mod9.nob", int'(b1), 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0); expectEq("mod9.q9", int'(q1), 9);
    expectEq("mod9.b", int'(b1), 1);
    applyStimulus(0, 0, 0, 0, 0, 0); expectEq("mod9.b_drop", int'(b1), 0);

    // Saturate: load 8, then three increments.
    applyStimulus(0, 1, 8, 0, 0, 1); expectEq("sat.ovf0", int'(ovf2), 0);
    applyStimulus(0, 0, 0, 1, 0, 0); expectEq("sat.q_a", int'(q2), 9);
    expectEq("sat.c_a", int'(c2), 0);
    applyStimulus(0, 0, 0, 1, 0, 0); expectEq("sat.q_b", int'(q2), 9);
    expectEq("sat.c_b", int'(c2), 1);
    expectEq("sat.ovf_b", int'(ovf2), 1);
    applyStimulus(0, 0, 0, 1, 0, 0); expectEq("sat.q_c", int'(q2), 9);
    expectEq("sat.c_c", int'(c2), 1);

    // Priority and clamp.
    applyStimulus(0, 1, 7, 0, 0, 1);
    applyStimulus(1, 1, 5, 0, 0, 0); expectEq("prio.clear", int'(q1), 0);
    applyStimulus(0, 1, 12, 0, 0, 0); expectEq("clamp.q", int'(q1), 9);
    expectEq("clamp.ovf", int'(ovf1), 1);
    applyStimulus(0, 1, 4, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0); expectEq("incdec.q", int'(q1), 4);
    expectEq("incdec.c", int'(c1), 0);
    expectEq("incdec.b", int'(b1), 0);
    applyStimulus(0, 1, 3, 1, 0, 0); expectEq("loadinc.c", int'(c0), 0);

    // Sticky flag: set, clear alone, then clear with a new carry.
    applyStimulus(0, 0, 0, 1, 0, 0); expectEq("sticky.set", int'(ovf0), 1);
    applyStimulus(0, 0, 0, 0, 0, 1); expectEq("sticky.clr", int'(ovf0), 0);
    applyStimulus(0, 1, 3, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 1); expectEq("sticky.setwins", int'(ovf0), 1);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                    int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 5) == 0);
    end

    // Asynchronous reset mid-cycle at q0=3 with a carry pending.
    applyStimulus(0, 1, 3, 0, 0, 0);
    inc = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    modelReset();
    checkOutput();
    expectEq("areset.q", int'(q0), 0);
    expectEq("areset.c", int'(c0), 0);
    expectEq("areset.ovf", int'(ovf0), 0);
    inc = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(0, 0, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
